// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM word adapter and future byte-lane users.
package sdram_pkg;

  localparam int unsigned HALFWORD_W = 16;
  localparam int unsigned STRB_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    MERGE,
    WR_ISSUE,
    WR_GUARD,
    NEXT,
    RESP
  } adapter_state_t;

  // Each byte lane takes the write byte when its strobe is set, else keeps the read byte.
  function automatic logic [HALFWORD_W-1:0] byte_merge(
    input logic [HALFWORD_W-1:0] rd_half,
    input logic [HALFWORD_W-1:0] wr_half,
    input logic [STRB_W-1:0]     strb
  );
    logic [HALFWORD_W-1:0] merged;
    merged[7:0]  = strb[0] ? wr_half[7:0]  : rd_half[7:0];
    merged[15:8] = strb[1] ? wr_half[15:8] : rd_half[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/sdram_word_adapter_if.sv
// Request/response bus between the AXI-Lite SDRAM shim and the word adapter.
interface sdram_word_adapter_if #(
  parameter int unsigned ADDR_WIDTH = 25
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic                  req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [3:0]            req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/sdram_beat_merge.sv
// Combinational byte merge of a read halfword with a partially strobed write halfword.
module sdram_beat_merge
  import sdram_pkg::*;
(
  input  logic [HALFWORD_W-1:0] rd_half,
  input  logic [HALFWORD_W-1:0] wr_half,
  input  logic [STRB_W-1:0]     strb,
  output logic [HALFWORD_W-1:0] merged_c
);

  assign merged_c = byte_merge(rd_half, wr_half, strb);

endmodule

// File: rtl/sdram_word_adapter.sv
// Splits word/halfword requests into 16-bit sdram_controller beats, with
// read-modify-write for single-byte strobes and one response per request.
module sdram_word_adapter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 25,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_word_adapter_if.slave   host,
  output logic [ADDR_WIDTH-2:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-2:0] rd_addr,
  output logic                  rd_enable,
  input  logic [15:0]           rd_data,
  input  logic                  rd_ready,
  input  logic                  busy
);

  localparam int unsigned HW_AW = ADDR_WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  adapter_state_t        state_q, state_d;
  logic                  beat_q, beat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lat_write_q, lat_write_d;
  logic                  lat_size_q, lat_size_d;
  logic [31:0]           lat_wdata_q, lat_wdata_d;
  logic [3:0]            lat_wstrb_q, lat_wstrb_d;
  logic [HW_AW-1:0]      hw_addr_q, hw_addr_d;
  logic [HALFWORD_W-1:0] wr_half_q, wr_half_d;
  logic [HALFWORD_W-1:0] rd_buf_q, rd_buf_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic [HW_AW-1:0]      wr_addr_q, wr_addr_d;
  logic [HALFWORD_W-1:0] wr_data_q, wr_data_d;
  logic                  wr_enable_q, wr_enable_d;
  logic [HW_AW-1:0]      rd_addr_q, rd_addr_d;
  logic                  rd_enable_q, rd_enable_d;

  logic                  misaligned_c;
  logic [STRB_W-1:0]     beat_strb_c;
  logic [HALFWORD_W-1:0] merged_c;

  // Entry state for a beat: reads and partial writes start with a read, empty beats are skipped.
  function automatic adapter_state_t beat_entry(input logic write, input logic [STRB_W-1:0] strb);
    adapter_state_t st;
    if (!write)              st = RD_ISSUE;
    else if (strb == 2'b11)  st = WR_ISSUE;
    else if (strb == 2'b00)  st = NEXT;
    else                     st = RD_ISSUE;
    return st;
  endfunction

  assign misaligned_c = host.req_size ? (host.req_addr[1:0] != 2'b00) : host.req_addr[0];
  assign beat_strb_c  = beat_q ? lat_wstrb_q[3:2] : lat_wstrb_q[1:0];

  sdram_beat_merge u_merge (
    .rd_half  (rd_buf_q),
    .wr_half  (wr_half_q),
    .strb     (beat_strb_c),
    .merged_c (merged_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    lat_write_d  = lat_write_q;
    lat_size_d   = lat_size_q;
    lat_wdata_d  = lat_wdata_q;
    lat_wstrb_d  = lat_wstrb_q;
    hw_addr_d    = hw_addr_q;
    wr_half_d    = wr_half_q;
    rd_buf_d     = rd_buf_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_addr_d    = rd_addr_q;
    wr_enable_d  = 1'b0;
    rd_enable_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (host.req_valid && host.req_ready) begin
          lat_write_d  = host.req_write;
          lat_size_d   = host.req_size;
          lat_wdata_d  = host.req_wdata;
          lat_wstrb_d  = host.req_wstrb;
          hw_addr_d    = host.req_addr[ADDR_WIDTH-1:1];
          wr_half_d    = host.req_wdata[15:0];
          beat_d       = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = 32'h0;
          if (misaligned_c) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else begin
            state_d = beat_entry(host.req_write, host.req_wstrb[1:0]);
          end
        end
      end
      RD_ISSUE: begin
        if (!busy) begin
          rd_enable_d = 1'b1;
          rd_addr_d   = hw_addr_q;
          cnt_d       = '0;
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Data arriving on the expiry cycle still wins over the timeout.
        if (rd_ready) begin
          if (lat_write_q) begin
            rd_buf_d = rd_data;
            state_d  = MERGE;
          end else begin
            if (beat_q) resp_rdata_d[31:16] = rd_data;
            else        resp_rdata_d[15:0]  = rd_data;
            state_d = NEXT;
          end
        end else if (cnt_q == CNT_LAST) begin
          resp_err_d = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MERGE: begin
        wr_half_d = merged_c;
        state_d   = WR_ISSUE;
      end
      WR_ISSUE: begin
        if (!busy) begin
          wr_enable_d = 1'b1;
          wr_addr_d   = hw_addr_q;
          wr_data_d   = wr_half_q;
          state_d     = WR_GUARD;
        end
      end
      WR_GUARD: state_d = NEXT;
      NEXT: begin
        if (lat_size_q && !beat_q) begin
          beat_d    = 1'b1;
          hw_addr_d = hw_addr_q + HW_AW'(1);
          wr_half_d = lat_wdata_q[31:16];
          state_d   = beat_entry(lat_write_q, lat_wstrb_q[3:2]);
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (host.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    resp_valid_d = (state_d == RESP);
    req_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= 1'b0;
      cnt_q        <= '0;
      lat_write_q  <= 1'b0;
      lat_size_q   <= 1'b0;
      lat_wdata_q  <= 32'h0;
      lat_wstrb_q  <= 4'h0;
      hw_addr_q    <= '0;
      wr_half_q    <= '0;
      rd_buf_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_enable_q  <= 1'b0;
      rd_addr_q    <= '0;
      rd_enable_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      cnt_q        <= cnt_d;
      lat_write_q  <= lat_write_d;
      lat_size_q   <= lat_size_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_wstrb_q  <= lat_wstrb_d;
      hw_addr_q    <= hw_addr_d;
      wr_half_q    <= wr_half_d;
      rd_buf_q     <= rd_buf_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_enable_q  <= wr_enable_d;
      rd_addr_q    <= rd_addr_d;
      rd_enable_q  <= rd_enable_d;
    end
  end

  assign host.req_ready  = req_ready_q;
  assign host.resp_valid = resp_valid_q;
  assign host.resp_err   = resp_err_q;
  assign host.resp_rdata = resp_rdata_q;
  assign wr_addr         = wr_addr_q;
  assign wr_data         = wr_data_q;
  assign wr_enable       = wr_enable_q;
  assign rd_addr         = rd_addr_q;
  assign rd_enable       = rd_enable_q;

endmodule

// File: tb/tb_sdram_word_adapter.sv
// Self-checking bench: controller model plus a transaction-level reference of the word adapter.
module tb_sdram_word_adapter;

  localparam int AW = 25;
  localparam int HW = AW - 1;
  localparam int TO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    bit          tmo;
    int          early;
    bit          unstable;
    logic        rdy_after;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy = 1'b0;
  logic          rd_ready;
  logic [15:0]   rd_data;
  logic [HW-1:0] wr_addr, rd_addr;
  logic [15:0]   wr_data;
  logic          wr_enable, rd_enable;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sdram_word_adapter_if #(.ADDR_WIDTH(AW)) host ();

  sdram_word_adapter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .host(host),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data),
    .rd_ready(rd_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- controller model ----------------
  logic [15:0]      mem [int];
  logic [15:0]      ref_mem [int];
  logic [HW+15:0]   wr_log [$];
  logic [HW-1:0]    rd_log [$];
  logic [HW+15:0]   exp_wr [$];
  logic [HW-1:0]    exp_rd [$];
  int  rd_delay = 0;
  bit  rd_mute  = 0;
  bit  pend     = 0;
  int  pcnt     = 0;
  int  paddr    = 0;
  int  dbl_pulse = 0;
  bit  prev_en  = 0;

  function automatic logic [15:0] init_val(int a);
    return 16'(a * 40503 + 12345);
  endfunction
  function automatic logic [15:0] mem_get(int a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  function automatic logic [15:0] ref_get(int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ready <= 1'b0;
      rd_data  <= 16'h0;
      pend     = 0;
      prev_en  = 0;
    end else begin
      rd_ready <= 1'b0;
      if (wr_enable) begin
        mem[int'(wr_addr)] = wr_data;
        wr_log.push_back({wr_addr, wr_data});
      end
      if (pend) begin
        if (pcnt == 0) begin
          rd_ready <= 1'b1;
          rd_data  <= mem_get(paddr);
          pend = 0;
        end else pcnt--;
      end
      if (rd_enable) begin
        rd_log.push_back(rd_addr);
        if (!rd_mute) begin pend = 1; pcnt = rd_delay; paddr = int'(rd_addr); end
      end
      if (prev_en && (wr_enable || rd_enable)) dbl_pulse++;
      prev_en = wr_enable || rd_enable;
    end
  end

  // ---------------- transaction-level reference ----------------
  task automatic ref_req(input logic w, input logic s, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         output logic [31:0] rdata, output logic err);
    int ha;
    int st;
    logic [15:0] d, m, nv;
    rdata = 32'h0;
    err   = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    if ((s && (a % 4 != 0)) || (!s && (a % 2 != 0))) begin
      err = 1'b1;
    end else begin
      for (int b = 0; b < (s ? 2 : 1); b++) begin
        ha = (int'(a / 2) + b) % (1 << HW);
        st = int'((ws >> (2 * b)) & 4'h3);
        d  = 16'(wd >> (16 * b));
        if (!w) begin
          exp_rd.push_back(HW'(ha));
          m = ref_get(ha);
          rdata = rdata | (32'(m) << (16 * b));
        end else if (st == 3) begin
          exp_wr.push_back({HW'(ha), d});
          ref_mem[ha] = d;
        end else if (st != 0) begin
          exp_rd.push_back(HW'(ha));
          m  = ref_get(ha);
          nv = (st == 1) ? ((m & 16'hFF00) | (d & 16'h00FF)) : ((m & 16'h00FF) | (d & 16'hFF00));
          exp_wr.push_back({HW'(ha), nv});
          ref_mem[ha] = nv;
        end
      end
    end
  endtask

  function automatic bit traffic_ok();
    if (wr_log.size() != exp_wr.size() || rd_log.size() != exp_rd.size()) return 0;
    foreach (exp_wr[i]) if (wr_log[i] !== exp_wr[i]) return 0;
    foreach (exp_rd[i]) if (rd_log[i] !== exp_rd[i]) return 0;
    return 1;
  endfunction

  // Drives one request, waits (bounded) for its response, then completes the handshake.
  task automatic run_req(input logic w, input logic s, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [3:0] ws,
                         input int busy_hold, input int ready_stall, output res_t r);
    int acc;
    int k;
    r = '{rdata: 32'h0, err: 1'b0, lat: -1, tmo: 0, early: 0, unstable: 0, rdy_after: 1'b0};
    wr_log.delete();
    rd_log.delete();
    @(negedge clk);
    host.req_write = w; host.req_size = s; host.req_addr = a;
    host.req_wdata = wd; host.req_wstrb = ws; host.req_valid = 1'b1;
    if (busy_hold > 0) busy = 1'b1;
    k = 0;
    while (!host.req_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    host.req_valid = 1'b0;
    acc = cyc;
    k = 0;
    while (!host.resp_valid && k < 400) begin
      if (busy && (cyc - acc) >= busy_hold) begin
        r.early = wr_log.size() + rd_log.size();
        busy = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    busy = 1'b0;
    if (!host.resp_valid) begin
      r.tmo = 1;
    end else begin
      r.lat   = cyc - acc;
      r.rdata = host.resp_rdata;
      r.err   = host.resp_err;
      repeat (ready_stall) begin
        @(negedge clk);
        if (!host.resp_valid || host.resp_rdata !== r.rdata || host.resp_err !== r.err) r.unstable = 1;
      end
      host.resp_ready = 1'b1;
      @(negedge clk);
      host.resp_ready = 1'b0;
      r.rdy_after = host.req_ready && !host.resp_valid;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({host.req_ready, host.resp_valid, host.resp_err} !== 3'b100) begin
      n_fail++; $display("FAIL reset_hs: got %b expected 100", {host.req_ready, host.resp_valid, host.resp_err});
    end
    n_checks++;
    if ({wr_enable, rd_enable, wr_addr, rd_addr, wr_data, host.resp_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outs: got we=%b re=%b wa=%h ra=%h wd=%h rdata=%h expected all zero",
                         wr_enable, rd_enable, wr_addr, rd_addr, wr_data, host.resp_rdata);
    end
  endtask

  task automatic test_word_write();
    res_t r; logic [31:0] er; logic ee;
    ref_req(1, 1, 25'h10, 32'hDEAD_BEEF, 4'hF, er, ee);
    run_req(1, 1, 25'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b0 || r.rdata !== 32'h0) begin
      n_fail++; $display("FAIL wwrite_resp: got tmo=%0b err=%b rdata=%h expected 0/0/0", r.tmo, r.err, r.rdata);
    end
    n_checks++;
    if (!traffic_ok() || wr_log.size() != 2 || wr_log[0] !== {24'h8, 16'hBEEF} || wr_log[1] !== {24'h9, 16'hDEAD}) begin
      n_fail++; $display("FAIL wwrite_traffic: got %0d writes %0d reads expected (8,BEEF),(9,DEAD) no reads",
                         wr_log.size(), rd_log.size());
    end
    n_checks++;
    if (r.lat != 6) begin n_fail++; $display("FAIL wwrite_latency: got %0d expected 6", r.lat); end
    n_checks++;
    if (r.rdy_after !== 1'b1) begin n_fail++; $display("FAIL wwrite_ready_after: got %b expected 1", r.rdy_after); end
  endtask

  task automatic test_word_read();
    res_t r; logic [31:0] er; logic ee;
    mem[32'h10] = 16'h1234; ref_mem[32'h10] = 16'h1234;
    mem[32'h11] = 16'hABCD; ref_mem[32'h11] = 16'hABCD;
    rd_delay = 2;
    ref_req(0, 1, 25'h20, 32'h0, 4'h0, er, ee);
    run_req(0, 1, 25'h20, 32'h0, 4'h0, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b0 || r.rdata !== 32'hABCD_1234) begin
      n_fail++; $display("FAIL wread_data: got tmo=%0b err=%b rdata=%h expected 0/0/abcd1234", r.tmo, r.err, r.rdata);
    end
    n_checks++;
    if (!traffic_ok()) begin
      n_fail++; $display("FAIL wread_traffic: got %0d reads %0d writes expected reads 10,11", rd_log.size(), wr_log.size());
    end
  endtask

  task automatic test_hw_rmw();
    res_t r; logic [31:0] er; logic ee;
    mem[3] = 16'h5566; ref_mem[3] = 16'h5566;
    rd_delay = 1;
    ref_req(1, 0, 25'h6, 32'h0000_00AA, 4'b0001, er, ee);
    run_req(1, 0, 25'h6, 32'h0000_00AA, 4'b0001, 0, 0, r);
    n_checks++;
    if (!traffic_ok() || wr_log.size() != 1 || wr_log[0] !== {24'h3, 16'h55AA}) begin
      n_fail++; $display("FAIL rmw_low_traffic: got %0d writes first=%h expected one write 000003_55aa", wr_log.size(),
                         (wr_log.size() > 0) ? wr_log[0] : 40'h0);
    end
    n_checks++;
    if (r.tmo || r.err !== 1'b0 || r.rdata !== 32'h0) begin
      n_fail++; $display("FAIL rmw_low_resp: got tmo=%0b err=%b rdata=%h expected 0/0/0", r.tmo, r.err, r.rdata);
    end
    // Beat0 skipped, beat1 upper byte only.
    ref_req(1, 1, 25'h30, 32'h7700_0000, 4'b1000, er, ee);
    run_req(1, 1, 25'h30, 32'h7700_0000, 4'b1000, 0, 0, r);
    n_checks++;
    if (!traffic_ok() || r.err !== 1'b0) begin
      n_fail++; $display("FAIL rmw_high_traffic: got %0d writes %0d reads err=%b expected %0d/%0d/0",
                         wr_log.size(), rd_log.size(), r.err, exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_misaligned();
    res_t r;
    run_req(0, 1, 25'h2, 32'h0, 4'h0, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b1 || r.lat > 2 || (wr_log.size() + rd_log.size()) != 0) begin
      n_fail++; $display("FAIL misaligned_word: got err=%b lat=%0d traffic=%0d expected err=1 lat<=2 traffic=0",
                         r.err, r.lat, wr_log.size() + rd_log.size());
    end
    run_req(1, 0, 25'h5, 32'h1111, 4'h3, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b1 || (wr_log.size() + rd_log.size()) != 0) begin
      n_fail++; $display("FAIL misaligned_half: got err=%b traffic=%0d expected err=1 traffic=0",
                         r.err, wr_log.size() + rd_log.size());
    end
  endtask

  task automatic test_stall();
    res_t r; logic [31:0] er; logic ee;
    ref_req(1, 1, 25'h100, 32'h0BAD_F00D, 4'hF, er, ee);
    run_req(1, 1, 25'h100, 32'h0BAD_F00D, 4'hF, 20, 5, r);
    n_checks++;
    if (r.early != 0) begin n_fail++; $display("FAIL stall_busy: got %0d pulses while busy expected 0", r.early); end
    n_checks++;
    if (r.unstable) begin n_fail++; $display("FAIL stall_resp_stable: got unstable=1 expected 0"); end
    n_checks++;
    if (r.tmo || !traffic_ok() || r.err !== 1'b0 || r.lat != 26) begin
      n_fail++; $display("FAIL stall_result: got tmo=%0b err=%b lat=%0d writes=%0d expected 0/0/26/2",
                         r.tmo, r.err, r.lat, wr_log.size());
    end
  endtask

  task automatic test_timeout();
    res_t r;
    rd_mute = 1;
    run_req(0, 0, 25'h40, 32'h0, 4'h0, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b1 || r.lat != TO + 1 || r.rdata !== 32'h0 || rd_log.size() != 1) begin
      n_fail++; $display("FAIL timeout_half: got err=%b lat=%0d rdata=%h reads=%0d expected 1/%0d/0/1",
                         r.err, r.lat, r.rdata, rd_log.size(), TO + 1);
    end
    run_req(0, 1, 25'h80, 32'h0, 4'h0, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b1 || rd_log.size() != 1) begin
      n_fail++; $display("FAIL timeout_word_abandon: got err=%b reads=%0d expected 1/1", r.err, rd_log.size());
    end
    rd_mute = 0;
    // rd_ready landing exactly on the expiry cycle, then one cycle late.
    mem[32'h50] = 16'hC0DE; ref_mem[32'h50] = 16'hC0DE;
    rd_delay = TO - 3;
    run_req(0, 0, 25'hA0, 32'h0, 4'h0, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b0 || r.rdata !== 32'h0000_C0DE) begin
      n_fail++; $display("FAIL timeout_tie: got err=%b rdata=%h expected 0/0000c0de", r.err, r.rdata);
    end
    rd_delay = TO - 2;
    run_req(0, 0, 25'hA0, 32'h0, 4'h0, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b1) begin n_fail++; $display("FAIL timeout_late: got err=%b expected 1", r.err); end
    rd_delay = 0;
    repeat (TO + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    res_t r; logic [31:0] er; logic ee;
    rd_mute = 1;
    @(negedge clk);
    host.req_write = 0; host.req_size = 0; host.req_addr = 25'h40; host.req_valid = 1'b1;
    @(negedge clk);
    host.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({host.req_ready, host.resp_valid, host.resp_err, rd_enable, wr_enable} !== 5'b10000 || rd_addr !== '0) begin
      n_fail++; $display("FAIL reset_mid: got rdy/rv/err/re/we=%b rd_addr=%h expected 10000/0",
                         {host.req_ready, host.resp_valid, host.resp_err, rd_enable, wr_enable}, rd_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    rd_mute = 0;
    @(negedge clk);
    n_checks++;
    if (host.req_ready !== 1'b1 || host.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got rdy=%b rv=%b expected 1/0", host.req_ready, host.resp_valid);
    end
    ref_req(0, 1, 25'h20, 32'h0, 4'h0, er, ee);
    run_req(0, 1, 25'h20, 32'h0, 4'h0, 0, 0, r);
    n_checks++;
    if (r.tmo || r.err !== 1'b0 || r.rdata !== er || !traffic_ok()) begin
      n_fail++; $display("FAIL reset_recover: got err=%b rdata=%h expected 0/%h", r.err, r.rdata, er);
    end
  endtask

  task automatic test_random();
    res_t r; logic [31:0] er; logic ee;
    logic w, s; logic [AW-1:0] a; logic [31:0] wd; logic [3:0] ws;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 255));
      a  = s ? (a & ~AW'(3)) : (a & ~AW'(1));
      if ($urandom_range(0, 7) == 0) a = a | AW'(s ? $urandom_range(1, 3) : 1);
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      rd_delay = $urandom_range(0, 4);
      ref_req(w, s, a, wd, ws, er, ee);
      run_req(w, s, a, wd, ws, 0, $urandom_range(0, 3), r);
      n_checks++;
      if (r.tmo || r.err !== ee || r.rdata !== er || !traffic_ok()) begin
        n_fail++; $display("FAIL random[%0d] w=%b s=%b a=%h ws=%h: got tmo=%0b err=%b rdata=%h wr=%0d rd=%0d expected err=%b rdata=%h wr=%0d rd=%0d",
                           i, w, s, a, ws, r.tmo, r.err, r.rdata, wr_log.size(), rd_log.size(), ee, er, exp_wr.size(), exp_rd.size());
      end
    end
    rd_delay = 0;
  endtask

  initial begin
    host.req_valid = 1'b0; host.req_write = 1'b0; host.req_size = 1'b0;
    host.req_addr = '0; host.req_wdata = 32'h0; host.req_wstrb = 4'h0; host.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_word_write();
    test_word_read();
    test_hw_rmw();
    test_misaligned();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    n_checks++;
    if (dbl_pulse != 0) begin n_fail++; $display("FAIL enable_pulse_width: got %0d multi-cycle pulses expected 0", dbl_pulse); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
